// File: rtl/reg_file_param.sv
// Parametrised register file: one write port, two registered read ports, post-reset clear sweep.
// Define RF_BYPASS_EN to forward same-edge write data to a read of the same address.
module reg_file_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re0,
  input  logic [ADDR_W-1:0] raddr0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  output logic              ready
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_ok;
  logic              byp0;
  logic              byp1;

  // Entry 0 is read-only when it is hardwired to zero.
  assign wr_ok = we && !((ZERO_REG != 0) && (waddr == '0));

`ifdef RF_BYPASS_EN
  assign byp0 = wr_ok && (waddr == raddr0);
  assign byp1 = wr_ok && (waddr == raddr1);
`else
  assign byp0 = 1'b0;
  assign byp1 = 1'b0;
`endif

  function automatic logic [DATA_W-1:0] rd_sel(
    input logic [ADDR_W-1:0] ra,
    input logic [DATA_W-1:0] arr_val,
    input logic              byp,
    input logic [DATA_W-1:0] wd
  );
    if ((ZERO_REG != 0) && (ra == '0)) return '0;
    if (byp) return wd;
    return arr_val;
  endfunction

  // Array storage: the sweep owns the write port until RUN; no reset on data.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state == CLEAR) mem[cnt] <= '0;
      else if (wr_ok)     mem[waddr] <= wdata;
    end
  end

  // Control FSM and registered read ports
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= CLEAR;
      cnt    <= '0;
      ready  <= 1'b0;
      rdata0 <= '0;
      rdata1 <= '0;
    end else begin
      case (state)
        CLEAR: begin
          cnt    <= cnt + ADDR_W'(1);
          rdata0 <= '0;
          rdata1 <= '0;
          if (cnt == LAST) begin
            state <= RUN;
            ready <= 1'b1;
          end
        end
        RUN: begin
          ready <= 1'b1;
          if (re0) rdata0 <= rd_sel(raddr0, mem[raddr0], byp0, wdata);
          if (re1) rdata1 <= rd_sel(raddr1, mem[raddr1], byp1, wdata);
        end
        default: begin
          state <= CLEAR;
          cnt   <= '0;
          ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_file_param.sv
// Scoreboard bench for reg_file_param: default instance plus a small ADDR_W=3/DATA_W=16 instance.
module tb_reg_file_param;

  logic        clk = 1'b0;
  logic        rst_n, we, re0, re1;
  logic [4:0]  waddr, raddr0, raddr1;
  logic [31:0] wdata;
  logic [31:0] rdata0, rdata1;
  logic        ready;

  logic        rst_n_b, we_b, re0_b, re1_b;
  logic [2:0]  waddr_b, raddr0_b, raddr1_b;
  logic [15:0] wdata_b, rdata0_b, rdata1_b;
  logic        ready_b;

  reg_file_param dut_a (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .re0(re0), .raddr0(raddr0), .rdata0(rdata0),
    .re1(re1), .raddr1(raddr1), .rdata1(rdata1), .ready(ready)
  );

  reg_file_param #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .we(we_b), .waddr(waddr_b), .wdata(wdata_b),
    .re0(re0_b), .raddr0(raddr0_b), .rdata0(rdata0_b),
    .re1(re1_b), .raddr1(raddr1_b), .rdata1(rdata1_b), .ready(ready_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          tag;
    int          kind;
    logic [31:0] exp;
    string       name;
  } item_t;

  item_t q[$];
  int    edge_cnt = 0;
  int    checks = 0;
  int    errors = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Monitor: compares every expectation due at the edge just passed.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].tag <= edge_cnt) begin
      item_t       it;
      logic [31:0] act;
      it = q.pop_front();
      case (it.kind)
        0:       act = rdata0;
        1:       act = rdata1;
        2:       act = {31'b0, ready};
        3:       act = {16'b0, rdata0_b};
        4:       act = {31'b0, ready_b};
        default: act = 'x;
      endcase
      checks++;
      if (act !== it.exp || it.tag != edge_cnt) begin
        errors++;
        $display("FAIL %s: got %h expected %h (edge %0d)", it.name, act, it.exp, it.tag);
      end
    end
  end

  task automatic expect_at(input int kind, input logic [31:0] v, input string nm);
    item_t it;
    it.tag  = edge_cnt + 1;
    it.kind = kind;
    it.exp  = v;
    it.name = nm;
    q.push_back(it);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sweep_a(input logic junk, input string nm);
    for (int i = 0; i < 32; i++) begin
      we     = junk;
      waddr  = i[4:0];
      wdata  = 32'hAAAAAAAA;
      re0    = junk;
      raddr0 = i[4:0];
      expect_at(2, {31'b0, (i == 31)}, $sformatf("%s_ready_%0d", nm, i));
      if (junk) expect_at(0, 32'h0, $sformatf("%s_rdata0_clear_%0d", nm, i));
      tick();
    end
    we  = 1'b0;
    re0 = 1'b0;
  endtask

  task automatic read_all_zero(input string nm);
    for (int i = 0; i < 32; i++) begin
      re0    = 1'b1;
      raddr0 = i[4:0];
      re1    = 1'b1;
      raddr1 = 5'(31 - i);
      expect_at(0, 32'h0, $sformatf("%s_p0_r%0d", nm, i));
      expect_at(1, 32'h0, $sformatf("%s_p1_r%0d", nm, 31 - i));
      tick();
    end
    re0 = 1'b0;
    re1 = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; we = 1'b0; re0 = 1'b0; re1 = 1'b0;
    waddr = '0; raddr0 = '0; raddr1 = '0; wdata = '0;
    rst_n_b = 1'b0; we_b = 1'b0; re0_b = 1'b0; re1_b = 1'b0;
    waddr_b = '0; raddr0_b = '0; raddr1_b = '0; wdata_b = '0;
    tick();

    // Reset state
    expect_at(2, 32'h0, "reset_ready");
    expect_at(0, 32'h0, "reset_rdata0");
    expect_at(1, 32'h0, "reset_rdata1");
    tick();
    rst_n = 1'b1;
    sweep_a(1'b0, "sweep0");

    // Pre-load every entry with all ones
    for (int i = 0; i < 32; i++) begin
      we = 1'b1; waddr = i[4:0]; wdata = 32'hFFFFFFFF;
      tick();
    end
    we = 1'b0;
    re0 = 1'b1; raddr0 = 5'd5; re1 = 1'b1; raddr1 = 5'd0;
    expect_at(0, 32'hFFFFFFFF, "preload_r5");
    expect_at(1, 32'h0, "preload_r0");
    tick();
    re0 = 1'b0; re1 = 1'b0;

    // One-cycle reset pulse, full sweep, everything reads zero
    rst_n = 1'b0;
    expect_at(2, 32'h0, "pulse_ready");
    expect_at(0, 32'h0, "pulse_rdata0");
    tick();
    rst_n = 1'b1;
    sweep_a(1'b0, "sweep1");
    read_all_zero("cleared");

    // Basic write/read and hold
    we = 1'b1; waddr = 5'd7; wdata = 32'hDEADBEEF;
    tick();
    we = 1'b0;
    re0 = 1'b1; raddr0 = 5'd7; re1 = 1'b1; raddr1 = 5'd7;
    expect_at(0, 32'hDEADBEEF, "basic_p0");
    expect_at(1, 32'hDEADBEEF, "basic_p1");
    tick();
    re0 = 1'b0; raddr0 = 5'd9; re1 = 1'b0;
    expect_at(0, 32'hDEADBEEF, "hold_p0");
    tick();

    // Zero register: separate and same-edge
    we = 1'b1; waddr = 5'd0; wdata = 32'h12345678;
    tick();
    we = 1'b0;
    re0 = 1'b1; raddr0 = 5'd0; re1 = 1'b1; raddr1 = 5'd0;
    expect_at(0, 32'h0, "zero_p0");
    expect_at(1, 32'h0, "zero_p1");
    tick();
    re0 = 1'b1; raddr0 = 5'd7; re1 = 1'b0;
    expect_at(0, 32'hDEADBEEF, "reload_r7");
    tick();
    we = 1'b1; waddr = 5'd0; wdata = 32'h12345678;
    re0 = 1'b1; raddr0 = 5'd0; re1 = 1'b1; raddr1 = 5'd0;
    expect_at(0, 32'h0, "zero_sameedge_p0");
    expect_at(1, 32'h0, "zero_sameedge_p1");
    tick();
    we = 1'b0; re0 = 1'b0; re1 = 1'b0;

    // Same-edge write/read of r3
    we = 1'b1; waddr = 5'd3; wdata = 32'h00000011;
    tick();
    wdata = 32'h00000022;
    re1 = 1'b1; raddr1 = 5'd3;
`ifdef RF_BYPASS_EN
    expect_at(1, 32'h00000022, "bypass_p1");
`else
    expect_at(1, 32'h00000011, "nobypass_p1");
`endif
    tick();
    we = 1'b0;
    re0 = 1'b1; raddr0 = 5'd3;
    expect_at(0, 32'h00000022, "after_write_p0");
    expect_at(1, 32'h00000022, "after_write_p1");
    tick();
    re0 = 1'b0; re1 = 1'b0;

    // Reset mid-sweep with junk writes throughout
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++) begin
      we = 1'b1; waddr = 5'(i + 3); wdata = 32'hAAAAAAAA;
      expect_at(2, 32'h0, $sformatf("midsweep_ready_%0d", i));
      tick();
    end
    rst_n = 1'b0;
    expect_at(2, 32'h0, "midsweep_reset_ready");
    tick();
    rst_n = 1'b1;
    sweep_a(1'b1, "sweep2");
    read_all_zero("recleared");

    // Small instance: 8-entry sweep, 16-bit data
    rst_n_b = 1'b1;
    for (int i = 0; i < 8; i++) begin
      expect_at(4, {31'b0, (i == 7)}, $sformatf("b_ready_%0d", i));
      tick();
    end
    we_b = 1'b1; waddr_b = 3'd7; wdata_b = 16'hBEEF;
    tick();
    we_b = 1'b0;
    re0_b = 1'b1; raddr0_b = 3'd7;
    expect_at(3, 32'h0000BEEF, "b_r7");
    tick();
    re0_b = 1'b0;
    tick();

    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file_param.md
# reg_file_param

Parametrised register file for the CPU datapath: one synchronous write port and two registered read ports, with configurable data width and depth, and an optional hardwired-zero entry. It adds a post-reset clear sweep that zeroes every entry, and a `ready` flag that gates the decode stage until the sweep finishes. An optional write-to-read bypass is selected at compile time. It sits between decode (read addresses) and writeback (write port).

## Interface
- `DATA_W`, default 32: width of each entry.
- `ADDR_W`, default 5: address width; depth is `DEPTH = 2**ADDR_W`.
- `ZERO_REG`, default 1: when 1, entry 0 always reads 0 and ignores writes.

- `clk` input, 1 bit: sole clock; all state updates on the rising edge.
- `rst_n` input, 1 bit: synchronous, active-low reset.
- `we` input, 1 bit: write enable.
- `waddr` input, `ADDR_W` bits: write address.
- `wdata` input, `DATA_W` bits: write data.
- `re0` input, 1 bit: read enable, port 0.
- `raddr0` input, `ADDR_W` bits: read address, port 0.
- `rdata0` output, `DATA_W` bits: registered read data, port 0.
- `re1` input, 1 bit: read enable, port 1.
- `raddr1` input, `ADDR_W` bits: read address, port 1.
- `rdata1` output, `DATA_W` bits: registered read data, port 1.
- `ready` output, 1 bit: high once the clear sweep has completed.

## Operation
- The FSM has two states, CLEAR and RUN, plus an `ADDR_W`-bit sweep counter `cnt`.
- **Reset** (`rst_n` low at an edge):
  - state goes to CLEAR and `cnt` to 0;
  - `rdata0`, `rdata1` and `ready` go to 0.
- **CLEAR** (each edge with `rst_n` high):
  - writes 0 to `mem[cnt]`, then increments `cnt`;
  - when `cnt == DEPTH-1`, clears that entry and moves to RUN;
  - `we`, `re0` and `re1` are ignored, `rdata0`/`rdata1` hold 0, and `ready` stays 0.
- **RUN**:
  - `ready` is 1;
  - a write occurs when `we` is high, except to address 0 when `ZERO_REG=1`;
  - a read port loads `mem[raddr]` into its `rdata` when its `re` is high, and holds its previous value when `re` is low;
  - when `ZERO_REG=1`, a read of address 0 returns 0 regardless of array contents.
- Both ports may read the same address in the same cycle; each gets identical data.
- RUN is left only via reset. Reset asserted mid-sweep or mid-run restarts the sweep from `cnt=0`; the array must be fully re-zeroed.
- No arithmetic is performed; the counter wraps naturally, but the state transition occurs exactly at `DEPTH-1`.

## Timing
- Read latency is 1 cycle: address and `re` sampled at edge N give `rdata` valid after edge N.
- Write latency is 1 cycle: data written at edge N is visible to a read sampled at edge N+1.
- Sweep length: `ready` rises at the DEPTH-th edge with `rst_n` high after reset. For the defaults, that is edge 32 after release.
- Same-edge write and read to the same address depends on `RF_BYPASS_EN` (see Configuration).
- A write to address 0 with `ZERO_REG=1` never bypasses; the read returns 0.

## Configuration
- Macro: `RF_BYPASS_EN`.
- **Defined:** on a same-edge write and read to the same non-zero address, `rdata` gets `wdata` (the new value). This applies to each port independently.
- **Undefined:** `rdata` gets the pre-write array contents (old value). Software or the pipeline must then insert a cycle between dependent writeback and decode.

## Test plan
- **Reset sweep:** pre-load all entries with 0xFFFFFFFF, pulse `rst_n` low for 1 cycle.
  - `ready` must be 0 for 31 edges and 1 after edge 32;
  - every address must then read 0x00000000.
- **Basic write/read:** in RUN, write 0xDEADBEEF to r7, then the next cycle `re0=1, raddr0=7`; `re1=1, raddr1=7`.
  - both `rdata` must be 0xDEADBEEF one cycle later;
  - with `re0` dropped, `rdata0` must hold that value.
- **Zero register:** with `ZERO_REG=1`, write 0x12345678 to r0, then read r0 on both ports.
  - both must return 0x00000000, including same-edge reads.
- **Bypass:** r3 holds 0x00000011. Write 0x00000022 to r3 and read r3 on port 1 at the same edge.
  - `rdata1` must be 0x00000022 with `RF_BYPASS_EN` defined;
  - `rdata1` must be 0x00000011 without it.
- **Reset mid-sweep:** assert `rst_n` low at sweep edge 10, then release.
  - `ready` must stay 0 for a further full 32-edge sweep;
  - all writes (`we=1`, `wdata=0xAAAAAAAA`) during CLEAR must be discarded.
- **Depth parameter:** with `ADDR_W=3`, `DATA_W=16`:
  - `ready` must rise after 8 edges;
  - a write of 0xBEEF to r7 must read back as 0xBEEF.
